// File: rtl/four_input_stimulus_gen.sv
// Stimulus sequencer for a four-input gate: sweeps binary, Gray or walking-one
// patterns onto out_a..out_d, holding each for HOLD_CYCLES clocks.
module four_input_stimulus_gen #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned LOOPS       = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] mode,
   output logic       out_a,
   output logic       out_b,
   output logic       out_c,
   output logic       out_d,
   output logic       valid,
   output logic       busy,
   output logic       done,
   output logic [3:0] pattern_idx
);

   localparam int unsigned IDX_W  = 4;
   localparam int unsigned PAT_W  = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned LCMP_W = CNT_W + 1;

   localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [LCMP_W-1:0] LOOPS_V    = LCMP_W'(LOOPS);
   localparam logic              LOOPS_INF  = (LOOPS == 0);
   localparam logic [IDX_W-1:0]  LAST_FULL  = IDX_W'(15);
   localparam logic [IDX_W-1:0]  LAST_WALK  = IDX_W'(3);
   localparam logic [1:0]        MODE_GRAY  = 2'b01;
   localparam logic [1:0]        MODE_WALK  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         mode_r, mode_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]   hold_cnt, hold_nxt;
   logic [CNT_W-1:0]   loop_cnt, loop_nxt;
   logic [PAT_W-1:0]   pat_r, pat_nxt;
   logic               valid_nxt, busy_nxt, done_nxt;
   logic [IDX_W-1:0]   last_idx_c;
   logic               final_sweep_c;

   // Pattern for a given sweep mode and index; mode 11 falls back to binary.
   function automatic logic [PAT_W-1:0] pat_of(input logic [1:0] m, input logic [IDX_W-1:0] i);
      logic [PAT_W-1:0] walk;
      walk = 4'b1000;
      case (m)
         MODE_GRAY: pat_of = i ^ (i >> 1);
         MODE_WALK: pat_of = walk >> i[1:0];
         default:   pat_of = i;
      endcase
   endfunction

   assign last_idx_c    = (mode_r == MODE_WALK) ? LAST_WALK : LAST_FULL;
   assign final_sweep_c = !LOOPS_INF && (({1'b0, loop_cnt} + LCMP_W'(1)) == LOOPS_V);

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         mode_r   <= 2'b00;
         idx      <= '0;
         hold_cnt <= '0;
         loop_cnt <= '0;
         pat_r    <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode_r   <= mode_nxt;
         idx      <= idx_nxt;
         hold_cnt <= hold_nxt;
         loop_cnt <= loop_nxt;
         pat_r    <= pat_nxt;
         valid    <= valid_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_r;
      idx_nxt   = idx;
      hold_nxt  = hold_cnt;
      loop_nxt  = loop_cnt;
      pat_nxt   = pat_r;
      valid_nxt = valid;
      busy_nxt  = busy;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            pat_nxt   = '0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            if (start) begin
               state_nxt = RUN;
               mode_nxt  = mode;
               idx_nxt   = '0;
               hold_nxt  = '0;
               loop_nxt  = '0;
               pat_nxt   = pat_of(mode, '0);
               valid_nxt = 1'b1;
               busy_nxt  = 1'b1;
            end
         end

         RUN: begin
            if (stop) begin
               // Abort takes priority over end-of-sweep, so no done pulse.
               state_nxt = IDLE;
               idx_nxt   = '0;
               hold_nxt  = '0;
               pat_nxt   = '0;
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
            end else if (hold_cnt == HOLD_LAST) begin
               hold_nxt = '0;
               if (idx == last_idx_c) begin
                  loop_nxt = loop_cnt + CNT_W'(1);
                  idx_nxt  = '0;
                  if (final_sweep_c) begin
                     state_nxt = DONE;
                     pat_nxt   = '0;
                     valid_nxt = 1'b0;
                     done_nxt  = 1'b1;
                  end else begin
                     pat_nxt = pat_of(mode_r, '0);
                  end
               end else begin
                  idx_nxt = idx + IDX_W'(1);
                  pat_nxt = pat_of(mode_r, idx + IDX_W'(1));
               end
            end else begin
               hold_nxt = hold_cnt + CNT_W'(1);
            end
         end

         DONE: begin
            state_nxt = IDLE;
            pat_nxt   = '0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end

         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            hold_nxt  = '0;
            pat_nxt   = '0;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign out_a       = pat_r[3];
   assign out_b       = pat_r[2];
   assign out_c       = pat_r[1];
   assign out_d       = pat_r[0];
   assign pattern_idx = idx;

endmodule
